// File: rtl/pattern_player.sv
// pattern_player: plays a packed symbol sequence as one-hot LED flashes, each followed by a dark gap.
// Latency: first LED lit the cycle after start; done pulses len*(ON_CYCLES+GAP_CYCLES) cycles after that.
// Backpressure: none; start is ignored unless idle, abort wins over everything. Tone option: PATTERN_PLAYER_TONE_EN.

module pattern_player #(
  parameter int MAX_LEN    = 25,
  parameter int SYM_W      = 3,
  parameter int ON_CYCLES  = 500,
  parameter int GAP_CYCLES = 250,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
`ifdef PATTERN_PLAYER_TONE_EN
  ,
  parameter int TONE_DIV_BASE = 50
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     reverse,
  input  logic [LEN_W-1:0]         length,
  input  logic [MAX_LEN*SYM_W-1:0] pattern,
  output logic [(2**SYM_W)-1:0]    led,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         idx,
  output logic                     tone
);

  localparam int LED_W   = 2**SYM_W;
  localparam int PAT_W   = MAX_LEN * SYM_W;
  localparam int TMR_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_pat;
  logic               r_rev;
  logic [LEN_W-1:0]   r_len;
  logic [TMR_W-1:0]   r_tmr;
  logic [LED_W-1:0]   r_led;
  logic               r_busy;
  logic               r_done;
  logic [LEN_W-1:0]   r_idx;

  state_t             w_state_nxt;
  logic [LED_W-1:0]   w_led_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [LEN_W-1:0]   w_idx_nxt;
  logic [TMR_W-1:0]   w_tmr_nxt;
  logic               w_snap;

  logic [LEN_W-1:0]   w_len_in;
  logic [LEN_W-1:0]   w_start_idx;
  logic [LEN_W-1:0]   w_step_idx;
  logic               w_last;

  // Mux-based lookup keeps every access inside the bus even for an unused index.
  function automatic logic [SYM_W-1:0] sym_at(input logic [PAT_W-1:0] pat,
                                              input logic [LEN_W-1:0] i);
    sym_at = '0;
    for (int n = 0; n < MAX_LEN; n++) begin
      if (i == LEN_W'(n)) sym_at = pat[n*SYM_W +: SYM_W];
    end
  endfunction

  function automatic logic [LED_W-1:0] onehot(input logic [SYM_W-1:0] s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

  assign w_len_in    = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
  assign w_start_idx = reverse ? (w_len_in - LEN_W'(1)) : '0;
  assign w_step_idx  = r_rev ? (r_idx - LEN_W'(1)) : (r_idx + LEN_W'(1));
  assign w_last      = r_rev ? (r_idx == '0) : (r_idx == (r_len - LEN_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_idx_nxt   = r_idx;
    w_tmr_nxt   = r_tmr;
    w_snap      = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_led_nxt   = '0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_snap = 1'b1;
            if (w_len_in == '0) begin
              w_state_nxt = ST_FIN;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_led_nxt   = '0;
            end else begin
              // Symbol comes straight off the bus: the snapshot lands on this same edge.
              w_state_nxt = ST_ON;
              w_idx_nxt   = w_start_idx;
              w_led_nxt   = onehot(sym_at(pattern, w_start_idx));
              w_busy_nxt  = 1'b1;
              w_tmr_nxt   = '0;
            end
          end
        end
        ST_ON: begin
          if (r_tmr == TMR_W'(ON_CYCLES - 1)) begin
            w_state_nxt = ST_GAP;
            w_led_nxt   = '0;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (r_tmr == TMR_W'(GAP_CYCLES - 1)) begin
            w_tmr_nxt = '0;
            if (w_last) begin
              w_state_nxt = ST_FIN;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end else begin
              w_state_nxt = ST_ON;
              w_idx_nxt   = w_step_idx;
              w_led_nxt   = onehot(sym_at(r_pat, w_step_idx));
            end
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        ST_FIN: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_led_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_rev   <= 1'b0;
      r_len   <= '0;
      r_tmr   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_idx   <= w_idx_nxt;
      if (w_snap) begin
        r_pat <= pattern;
        r_rev <= reverse;
        r_len <= w_len_in;
      end
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;
  assign idx  = r_idx;

`ifdef PATTERN_PLAYER_TONE_EN
  localparam int TDIV_W = $clog2(TONE_DIV_BASE * LED_W + 1);

  logic              r_tone;
  logic [TDIV_W-1:0] r_tcnt;
  logic [SYM_W-1:0]  w_cur_sym;
  logic [TDIV_W-1:0] w_tdiv;

  assign w_cur_sym = sym_at(r_pat, r_idx);
  assign w_tdiv    = TDIV_W'(TONE_DIV_BASE) * (TDIV_W'(w_cur_sym) + TDIV_W'(1));

  // Half-period restarts low on every ON entry so each flash begins in phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone <= 1'b0;
      r_tcnt <= '0;
    end else if ((w_state_nxt != ST_ON) || (r_state != ST_ON)) begin
      r_tone <= 1'b0;
      r_tcnt <= '0;
    end else if (r_tcnt == (w_tdiv - TDIV_W'(1))) begin
      r_tone <= ~r_tone;
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TDIV_W'(1);
    end
  end

  assign tone = r_tone;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: timeline model computed from playback start, per-cycle compare, plus literal anchors.
module tb_pattern_player;

  localparam int MAX_LEN = 25;
  localparam int SYM_W   = 3;
  localparam int ON      = 4;
  localparam int GAP     = 2;
  localparam int P       = ON + GAP;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int PAT_W   = MAX_LEN * SYM_W;
`ifdef PATTERN_PLAYER_TONE_EN
  localparam int TDB     = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             reverse = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic [PAT_W-1:0] pattern = '0;
  logic [7:0]       led;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] idx;
  logic             tone;

  int checks = 0;
  int errors = 0;

  pattern_player #(
    .MAX_LEN(MAX_LEN), .SYM_W(SYM_W), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .LEN_W(LEN_W)
`ifdef PATTERN_PLAYER_TONE_EN
    , .TONE_DIV_BASE(TDB)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .reverse(reverse),
    .length(length), .pattern(pattern), .led(led), .busy(busy), .done(done),
    .idx(idx), .tone(tone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference: playback is a fixed timeline from the accepting edge m_k.
  int               e_cnt = 0;
  int               m_k = 0;
  bit               m_act = 1'b0;
  int               m_len = 0;
  bit               m_rev = 1'b0;
  logic [PAT_W-1:0] m_pat = '0;
  int               m_idx_hold = 0;

  function automatic int exp_idx(input int p);
    int slot;
    if (!m_act || m_len == 0) return m_idx_hold;
    slot = p / P;
    if (slot > m_len - 1) slot = m_len - 1;
    return m_rev ? (m_len - 1 - slot) : slot;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  pprev;
    bit  idle;
    if (!rst_n) begin
      m_act      = 1'b0;
      m_idx_hold = 0;
    end else begin
      e_cnt = e_cnt + 1;
      pprev = e_cnt - 1 - m_k;
      idle  = !m_act || (pprev > m_len * P);
      if (abort) begin
        if (!idle) begin
          m_idx_hold = exp_idx(pprev);
          m_act      = 1'b0;
        end
      end else if (start && idle) begin
        m_idx_hold = exp_idx(pprev);
        m_act      = 1'b1;
        m_k        = e_cnt;
        m_len      = (int'(length) > MAX_LEN) ? MAX_LEN : int'(length);
        m_rev      = reverse;
        m_pat      = pattern;
      end
    end
  end

  always @(negedge clk) begin
    int p, ei, s, eled, ebusy, edone, etone;
    p     = e_cnt - m_k;
    ei    = exp_idx(p);
    eled  = 0;
    ebusy = 0;
    edone = 0;
    etone = 0;
    if (m_act) begin
      if (p < m_len * P) begin
        ebusy = 1;
        if ((p % P) < ON) begin
          s    = int'(m_pat[ei*SYM_W +: SYM_W]);
          eled = 1 << s;
`ifdef PATTERN_PLAYER_TONE_EN
          etone = ((p % P) / (TDB * (s + 1))) % 2;
`endif
        end
      end else if (p == m_len * P) begin
        edone = 1;
      end
    end
    chk("cmp_led", 32'(led), eled);
    chk("cmp_busy", 32'(busy), ebusy);
    chk("cmp_done", 32'(done), edone);
    chk("cmp_idx", 32'(idx), ei);
    chk("cmp_tone", 32'(tone), etone);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After this returns the bench sits in spec cycle k+1 of the new playback.
  task automatic play(input int len, input bit rev);
    length  = LEN_W'(len);
    reverse = rev;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic std_pattern();
    pattern        = '0;
    pattern[2:0]   = 3'd5;
    pattern[5:3]   = 3'd0;
    pattern[8:6]   = 3'd7;
  endtask

  initial begin
    logic [PAT_W-1:0] saved;
    int exp_tone3;

    repeat (3) tick();
    chk("reset_led", 32'(led), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_idx", 32'(idx), 0);
    rst_n = 1'b1;
    tick();

    // Forward, with ignored starts (including one in FIN) and a mid-play pattern change.
    std_pattern();
    saved = pattern;
    play(3, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      case (c)
        1:  begin chk("fwd_led1", 32'(led), 32'h20); chk("fwd_busy1", 32'(busy), 1); end
        5:  chk("fwd_gap1", 32'(led), 0);
        7:  chk("fwd_led2", 32'(led), 32'h01);
        13: begin chk("fwd_led3", 32'(led), 32'h80); chk("fwd_idx3", 32'(idx), 2); end
        18: chk("fwd_busy18", 32'(busy), 1);
        19: begin chk("fwd_done", 32'(done), 1); chk("fwd_busy19", 32'(busy), 0); end
        20: begin chk("fwd_done_end", 32'(done), 0); chk("fwd_idx_hold", 32'(idx), 2); end
        default: ;
      endcase
      start = (c == 3 || c == 9 || c == 19);
      if (c == 5) pattern = ~pattern;
      tick();
    end
    start   = 1'b0;
    pattern = saved;

    // Reverse.
    play(3, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      case (c)
        1:  begin chk("rev_led1", 32'(led), 32'h80); chk("rev_idx1", 32'(idx), 2); end
        7:  begin chk("rev_led2", 32'(led), 32'h01); chk("rev_idx2", 32'(idx), 1); end
        13: begin chk("rev_led3", 32'(led), 32'h20); chk("rev_idx3", 32'(idx), 0); end
        19: chk("rev_done", 32'(done), 1);
        default: ;
      endcase
      tick();
    end

    // Zero length, then clamped length.
    play(0, 1'b0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_led", 32'(led), 0);
    tick();
    chk("zero_done_end", 32'(done), 0);
    tick();
    play(31, 1'b0);
    for (int c = 1; c <= 152; c++) begin
      case (c)
        145: chk("clamp_idx", 32'(idx), 24);
        150: chk("clamp_busy", 32'(busy), 1);
        151: chk("clamp_done", 32'(done), 1);
        default: ;
      endcase
      tick();
    end

    // Abort during the second ON.
    play(3, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      abort = (c == 8);
      if (c == 9) begin
        chk("abort_led", 32'(led), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_idx", 32'(idx), 1);
      end
      if (c == 19) chk("abort_nodone", 32'(done), 0);
      tick();
    end
    abort = 1'b0;

    // Async reset mid-GAP, mid-cycle.
    play(3, 1'b0);
    for (int c = 1; c < 11; c++) tick();
    chk("pre_rst_idx", 32'(idx), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_idx", 32'(idx), 0);
    chk("arst_done", 32'(done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Tone: symbol 0 then symbol 1.
    pattern      = '0;
    pattern[5:3] = 3'd1;
`ifdef PATTERN_PLAYER_TONE_EN
    exp_tone3 = 1;
`else
    exp_tone3 = 0;
`endif
    play(2, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) chk("tone_c2", 32'(tone), 0);
      if (c == 3) chk("tone_c3", 32'(tone), exp_tone3);
      if (c == 5) chk("tone_gap", 32'(tone), 0);
      tick();
    end

    // Randomized traffic with async resets sprinkled in.
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom % 6 == 0);
      abort   = ($urandom % 80 == 0);
      reverse = $urandom % 2;
      length  = ($urandom % 4 == 0) ? LEN_W'($urandom_range(0, 31)) : LEN_W'($urandom_range(0, 5));
      if ($urandom % 3 == 0) pattern = PAT_W'({$urandom, $urandom, $urandom});
      if ($urandom % 700 == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Playback end of the memory-game pattern path: reads the packed 3-bit symbol sequence written by the pattern shift register and plays it out on the 8 pattern LEDs, one symbol at a time.
- Each symbol is shown as one-hot on `led` for a fixed on-time, followed by a blank gap.
- This is the inverse of the button one-hot-to-binary encoder.
- The mode FSMs drive it with a start/abort handshake and wait on busy/done before enabling input capture.

Parameters:
- MAX_LEN, 25, maximum symbols stored; the pattern bus is MAX_LEN*SYM_W bits.
- SYM_W, 3, bits per symbol; LED width is 2**SYM_W = 8.
- ON_CYCLES, 500, clock cycles each symbol's LED is lit (>=1).
- GAP_CYCLES, 250, clock cycles of dark gap after each symbol (>=1).
- LEN_W, $clog2(MAX_LEN+1), width of the length and index ports.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request playback; sampled only in IDLE.
- abort  input  1  stop playback immediately.
- reverse  input  1  playback order select; sampled with start.
- length  input  LEN_W  number of symbols to play; sampled with start.
- pattern  input  MAX_LEN*SYM_W  packed symbols; symbol i occupies bits [SYM_W*i+SYM_W-1 : SYM_W*i].
- led  output  8  one-hot symbol display; 0 when dark.
- busy  output  1  high while playing.
- done  output  1  one-cycle pulse when playback completes.
- idx  output  LEN_W  index of the symbol currently or last shown.
- tone  output  1  audio square wave (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; led=0, busy=0, done=0, idx=0, tone=0; timers and snapshot cleared.
- All outputs are registered.
- States: IDLE, ON, GAP, FIN.
- IDLE:
  - start=1 and abort=0 → snapshot pattern, reverse and len = min(length, MAX_LEN).
  - If len=0 → FIN.
  - Else → ON with idx = reverse ? len-1 : 0.
- ON:
  - led = 1<<sym[idx], busy=1.
  - Holds for exactly ON_CYCLES cycles, then → GAP.
- GAP:
  - led=0, busy=1.
  - Holds for exactly GAP_CYCLES cycles.
  - If the last symbol was just played (idx = len-1 forward, or idx = 0 reverse) → FIN.
  - Else step idx (+1 forward, -1 reverse) → ON.
- FIN: done=1 and busy=0 for exactly one cycle, then → IDLE. idx holds its last value until the next start.
- Latency:
  - start sampled at edge k → first led lit in cycle k+1.
  - done high in cycle k+1+len*(ON_CYCLES+GAP_CYCLES).
  - len=0 → done in cycle k+1 with no LED activity.
- The snapshot isolates playback: changes to pattern, length or reverse during playback have no effect.
- start while not IDLE (including FIN) is ignored.
- abort in any state → IDLE next cycle: led=0, busy=0, no done pulse, idx unchanged. abort has priority over start when both are asserted in IDLE.
- Reset mid-playback → immediate reset values; no done pulse.
- Timer widths must hold max(ON_CYCLES, GAP_CYCLES) with no wrap.
- idx arithmetic never goes below 0 or above len-1.

Optional Feature:
- Macro: PATTERN_PLAYER_TONE_EN.
- When defined:
  - Adds parameter TONE_DIV_BASE (default 50).
  - During ON, tone toggles every TONE_DIV_BASE*(sym+1) cycles, giving a distinct pitch per symbol.
  - tone starts low at ON entry and is forced to 0 in IDLE, GAP and FIN.
- When undefined: tone is tied to 0 and no divider logic is built. The port exists in both builds.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, MAX_LEN=25; add TONE_DIV_BASE=2 for scenario 6):
1. Forward playback:
   - Stimulus: length=3, symbols {0:5, 1:0, 2:7}, reverse=0, start pulse at edge k.
   - Required: led=0x20 in cycles k+1..k+4, 0 in k+5..k+6, 0x01 in k+7..k+10, 0 in k+11..k+12, 0x80 in k+13..k+16, 0 in k+17..k+18.
   - Required: done=1 only in cycle k+19; busy high k+1..k+18.
2. Reverse playback:
   - Stimulus: same pattern, reverse=1.
   - Required: LED order 0x80, 0x01, 0x20 with the same timing; idx sequence 2, 1, 0; done in cycle k+19.
3. Zero length and clamping:
   - length=0 → done in cycle k+1, led stays 0, busy stays 0.
   - length=31 → exactly 25 symbols play; done in cycle k+1+25*6 = k+151.
4. Abort and ignored start:
   - Stimulus: abort during the second ON of scenario 1.
   - Required: led=0 and busy=0 next cycle; no done pulse.
   - Stimulus: start pulses during playback.
   - Required: no restart; timing identical to scenario 1.
5. Async reset and snapshot:
   - Stimulus: rst_n low mid-GAP, mid-cycle.
   - Required: outputs reach reset values before the next edge.
   - Stimulus: change pattern during playback.
   - Required: LEDs still show the values snapshotted at start.
6. PATTERN_PLAYER_TONE_EN build:
   - Stimulus: sym=0, then sym=1.
   - Required: sym=0 → tone toggles every 2 cycles during ON; sym=1 → every 4 cycles; tone=0 in GAP.
   - Without the macro: tone is constantly 0.
